// File: rtl/sample_seq_pkg.sv
// sample_seq_pkg: shared FSM state type, direction codes and default geometry
// for the sample sequencer.
package sample_seq_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, EMIT} state_t;
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;
    localparam int DEFAULT_ADDR_W = 23;
    localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_LAST_ADDR = 23'h7FFFF;
endpackage

// File: rtl/sample_sequencer_if.sv
// sample_sequencer_if: playback control, flash read handshake and audio output
// of the sample sequencer.
//   control: sample_tick, play, direction, restart (into the sequencer)
//   flash:   read_start, flash_address (out); read_finish, flash_readdata (in)
//   audio:   audio_sample, sample_valid, overrun (out)
// master = sequencer side, slave = environment side.
interface sample_sequencer_if import sample_seq_pkg::*; #(parameter int ADDR_W = DEFAULT_ADDR_W);
    logic              sample_tick;
    logic              play;
    logic              direction;
    logic              restart;
    logic              read_start;
    logic [ADDR_W-1:0] flash_address;
    logic              read_finish;
    logic [31:0]       flash_readdata;
    logic [15:0]       audio_sample;
    logic              sample_valid;
    logic              overrun;
    modport master (
        input  sample_tick, play, direction, restart, read_finish, flash_readdata,
        output read_start, flash_address, audio_sample, sample_valid, overrun
    );
    modport slave (
        output sample_tick, play, direction, restart, read_finish, flash_readdata,
        input  read_start, flash_address, audio_sample, sample_valid, overrun
    );
endinterface

// File: rtl/sample_sequencer_wrap_addr_counter.sv
// wrap_addr_counter: loadable up/down word-address counter wrapping over 0..LAST_ADDR.
//   clk, reset_n: clock, async active-low reset (address 0)
//   step: advance one word in direction dir (DIR_FWD up, DIR_BWD down)
//   load, load_value: overwrite the address (takes priority over step)
//   addr: current address
module wrap_addr_counter import sample_seq_pkg::*; #(
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] LAST_ADDR = DEFAULT_LAST_ADDR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              step,
    input  logic              dir,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] addr
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    always_comb begin
        addr_d = addr_q;
        if (load)
            addr_d = load_value;
        else if (step)
            addr_d = (dir == DIR_FWD) ? ((addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1)
                                      : ((addr_q == '0) ? LAST_ADDR : addr_q - 1'b1);
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) addr_q <= '0;
        else          addr_q <= addr_d;
    assign addr = addr_q;
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: steps through the song region of flash, fetching one word per
// two sample ticks and presenting its 16-bit halves as audio samples.
//   clk, reset_n: clock, async active-low reset
//   bus (master): control inputs, flash read handshake, audio outputs
module sample_sequencer import sample_seq_pkg::*; #(
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] LAST_ADDR = DEFAULT_LAST_ADDR
) (
    input  logic                clk,
    input  logic                reset_n,
    sample_sequencer_if.master  bus
);
    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic        full_q, full_d;
    logic        half_q, half_d;
    logic        pend_q, pend_d;
    logic [15:0] audio_q, audio_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic        step, load;
    logic [ADDR_W-1:0] addr;

    wrap_addr_counter #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR)) u_addr (
        .clk        (clk),
        .reset_n    (reset_n),
        .step       (step),
        .dir        (bus.direction),
        .load       (load),
        .load_value ((bus.direction == DIR_FWD) ? '0 : LAST_ADDR),
        .addr       (addr)
    );

    // half_q is the physical half (0 = [15:0], 1 = [31:16]) to emit next. A word is
    // finished once the half that comes last in the current direction is emitted.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        full_d  = full_q;
        half_d  = half_q;
        pend_d  = pend_q | bus.restart;
        audio_d = audio_q;
        valid_d = 1'b0;
        ovr_d   = bus.sample_tick && state_q != IDLE;
        step    = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                // A restart (fresh or deferred from a fetch) beats a same-cycle tick.
                if (pend_q || bus.restart) begin
                    load   = 1'b1;
                    full_d = 1'b0;
                    half_d = 1'b0;
                    pend_d = 1'b0;
                end else if (bus.sample_tick && bus.play)
                    state_d = full_q ? EMIT : FETCH;
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                if (bus.read_finish) begin
                    // With a restart pending the word is dropped; IDLE applies the restart.
                    state_d = (pend_q || bus.restart) ? IDLE : EMIT;
                    if (!(pend_q || bus.restart)) begin
                        word_d = bus.flash_readdata;
                        full_d = 1'b1;
                        half_d = (bus.direction == DIR_BWD);
                    end
                end
            end
            EMIT: begin
                audio_d = half_q ? word_q[31:16] : word_q[15:0];
                valid_d = 1'b1;
                state_d = IDLE;
                if (half_q == (bus.direction == DIR_FWD)) begin
                    full_d = 1'b0;
                    half_d = 1'b0;
                    step   = 1'b1;
                end else
                    half_d = ~half_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            full_q  <= 1'b0;
            half_q  <= 1'b0;
            pend_q  <= 1'b0;
            audio_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            full_q  <= full_d;
            half_q  <= half_d;
            pend_q  <= pend_d;
            audio_q <= audio_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end

    assign bus.read_start    = (state_q == FETCH);
    assign bus.flash_address = addr;
    assign bus.audio_sample  = audio_q;
    assign bus.sample_valid  = valid_q;
    assign bus.overrun       = ovr_q;
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: scoreboard bench with a flash responder model.
module tb_sample_sequencer;
    localparam logic [22:0] LAST = 23'h7FFFF;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sample_sequencer_if #(.ADDR_W(23)) bus();
    sample_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));

    int checks = 0, errors = 0;
    int rs_cnt = 0, sv_cnt = 0, ovr_cnt = 0, stable_err = 0;
    int lat = 2;
    logic [22:0] exp_addr[$];
    logic [15:0] exp_smp[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [22:0] a);
        if (a == 23'd0) return 32'hAAAA_5555;
        if (a == LAST)  return 32'h1234_5678;
        return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h0F0F};
    endfunction

    // Flash read FSM stand-in: finishes lat+1 cycles after seeing read_start.
    initial begin
        logic pending = 1'b0;
        logic [22:0] a = '0;
        int cnt = 0;
        bus.read_finish = 1'b0;
        bus.flash_readdata = '0;
        forever begin
            @(negedge clk);
            bus.read_finish = 1'b0;
            if (!reset_n) pending = 1'b0;
            else if (pending) begin
                if (bus.flash_address != a) stable_err++;
                if (cnt == 0) begin
                    bus.read_finish = 1'b1;
                    bus.flash_readdata = word_at(a);
                    pending = 1'b0;
                end else cnt--;
            end else if (bus.read_start) begin
                pending = 1'b1;
                a = bus.flash_address;
                cnt = lat;
            end
        end
    end

    // Output monitor: pops the scoreboard on every read_start / sample_valid.
    initial forever begin
        @(negedge clk);
        if (bus.read_start) begin
            rs_cnt++;
            if (exp_addr.size() == 0) check("extra_read", 1, 0);
            else check("read_addr", 32'(bus.flash_address), 32'(exp_addr.pop_front()));
        end
        if (bus.sample_valid) begin
            sv_cnt++;
            if (exp_smp.size() == 0) check("extra_sample", 1, 0);
            else check("sample", 32'(bus.audio_sample), 32'(exp_smp.pop_front()));
        end
        if (bus.overrun) ovr_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
    endtask

    task automatic do_restart(input logic dir);
        @(negedge clk);
        bus.direction = dir;
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
    endtask

    task automatic fetch_tick(input logic [22:0] a, input logic [15:0] s);
        exp_addr.push_back(a);
        exp_smp.push_back(s);
        tick();
        idle(lat + 8);
    endtask

    task automatic buf_tick(input logic [15:0] s);
        exp_smp.push_back(s);
        tick();
        idle(5);
    endtask

    initial begin
        int rs0, sv0, ov0;
        logic [31:0] w;
        bus.sample_tick = 1'b0;
        bus.play = 1'b1;
        bus.direction = 1'b0;
        bus.restart = 1'b0;
        idle(3);
        check("rst_read_start", 32'(bus.read_start), 0);
        check("rst_sample_valid", 32'(bus.sample_valid), 0);
        check("rst_audio", 32'(bus.audio_sample), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        check("rst_addr", 32'(bus.flash_address), 0);
        reset_n = 1'b1;
        idle(2);
        // tick together with restart in IDLE: restart wins, tick silently dropped
        @(negedge clk);
        bus.sample_tick = 1'b1;
        bus.restart = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        bus.restart = 1'b0;
        idle(8);
        check("tick_restart_reads", rs_cnt, 0);
        check("tick_restart_samples", sv_cnt, 0);
        check("tick_restart_overrun", ovr_cnt, 0);
        // forward walk
        fetch_tick(0, 16'h5555);
        rs0 = rs_cnt;
        buf_tick(16'hAAAA);
        check("no_read_second_half", rs_cnt, rs0);
        w = word_at(1);
        fetch_tick(1, w[15:0]);
        // backward from restart
        do_restart(1'b1);
        fetch_tick(LAST, 16'h1234);
        buf_tick(16'h5678);
        w = word_at(LAST - 1);
        fetch_tick(LAST - 1, w[31:16]);
        buf_tick(w[15:0]);
        // forward wrap LAST -> 0
        do_restart(1'b1);
        bus.direction = 1'b0;
        fetch_tick(LAST, 16'h5678);
        buf_tick(16'h1234);
        fetch_tick(0, 16'h5555);
        // backward wrap 0 -> LAST
        do_restart(1'b0);
        bus.direction = 1'b1;
        fetch_tick(0, 16'hAAAA);
        buf_tick(16'h5555);
        fetch_tick(LAST, 16'h1234);
        // restart during WAIT with slow flash
        do_restart(1'b0);
        fetch_tick(0, 16'h5555);
        buf_tick(16'hAAAA);
        lat = 10;
        rs0 = rs_cnt;
        sv0 = sv_cnt;
        exp_addr.push_back(1);
        tick();
        idle(3);
        do_restart(1'b0);
        idle(20);
        check("restart_wait_reads", rs_cnt - rs0, 1);
        check("restart_wait_samples", sv_cnt - sv0, 0);
        fetch_tick(0, 16'h5555);
        // tick during WAIT
        buf_tick(16'hAAAA);
        rs0 = rs_cnt;
        sv0 = sv_cnt;
        ov0 = ovr_cnt;
        w = word_at(1);
        exp_addr.push_back(1);
        exp_smp.push_back(w[15:0]);
        tick();
        idle(3);
        tick();
        idle(25);
        check("wait_tick_overrun", ovr_cnt - ov0, 1);
        check("wait_tick_samples", sv_cnt - sv0, 1);
        check("wait_tick_reads", rs_cnt - rs0, 1);
        // paused ticks
        rs0 = rs_cnt;
        sv0 = sv_cnt;
        ov0 = ovr_cnt;
        bus.play = 1'b0;
        repeat (5) begin
            tick();
            idle(3);
        end
        check("pause_reads", rs_cnt - rs0, 0);
        check("pause_samples", sv_cnt - sv0, 0);
        check("pause_overrun", ovr_cnt - ov0, 0);
        check("pause_audio_hold", 32'(bus.audio_sample), 32'(w[15:0]));
        bus.play = 1'b1;
        buf_tick(w[31:16]);
        // reset in the middle of WAIT
        exp_addr.push_back(2);
        tick();
        idle(4);
        reset_n = 1'b0;
        #1;
        check("mid_rst_read_start", 32'(bus.read_start), 0);
        check("mid_rst_sample_valid", 32'(bus.sample_valid), 0);
        check("mid_rst_audio", 32'(bus.audio_sample), 0);
        check("mid_rst_overrun", 32'(bus.overrun), 0);
        check("mid_rst_addr", 32'(bus.flash_address), 0);
        idle(3);
        reset_n = 1'b1;
        idle(20);
        check("addr_stable", stable_err, 0);
        check("left_reads", exp_addr.size(), 0);
        check("left_samples", exp_smp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
